// File: rtl/complement_seq_if.sv
// rtl/complement_seq_if.sv - operand/result bundle for the chunked complement unit
//
// Purpose: groups the request side (start/mode/data) and the response side
// (result/busy/done/ovf/zero) of complement_seq so a requester and the unit
// can be connected through one port.
//
// Signals (WIDTH = operand width):
//   start   requester -> unit  1      request, honoured only while busy=0
//   mode    requester -> unit  2      00 pass, 01 negate, 10 abs, 11 1's complement
//   data    requester -> unit  WIDTH  operand, captured together with start
//   result  unit -> requester  WIDTH  registered result of the last completed op
//   busy    unit -> requester  1      operation in progress
//   done    unit -> requester  1      one-cycle pulse when result/ovf/zero update
//   ovf     unit -> requester  1      negate/abs of the most negative value
//   zero    unit -> requester  1      result == 0
//
// Modports: master = requester, slave = complement_seq.
interface complement_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, data,
    input  result, busy, done, ovf, zero
  );

  modport slave (
    input  start, mode, data,
    output result, busy, done, ovf, zero
  );
endinterface

// File: rtl/complement_seq.sv
// rtl/complement_seq.sv - multi-cycle chunked 2's complement / sign manipulation unit
//
// Purpose: computes pass, negate, absolute value or 1's complement of a WIDTH-bit
// operand, CHUNK bits per clock, rippling the carry from chunk to chunk.
// One operation takes N = WIDTH/CHUNK RUN cycles followed by a one-cycle FIN
// state that pulses done; a new request may be accepted in FIN.
//
// Ports:
//   i_clk    in   1     clock, all state changes on the rising edge
//   i_reset  in   1     synchronous reset, active-high, aborts any operation
//   bus      slave      request/response bundle (see complement_seq_if)
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of CHUNK
//   CHUNK  bits processed per clock
module complement_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  complement_seq_if.slave     bus
);

  // A partial top chunk has no defined meaning for the carry ripple.
  if (WIDTH % CHUNK != 0) begin : g_cfg_error
    $error("complement_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_inv;
  // Whether the captured operand is an overflow case; decided once at accept
  // so the operand register is free to be consumed chunk by chunk.
  logic             r_ovf_cand;
  // Operand shifts right by CHUNK each RUN cycle so the chunk in flight is
  // always at the bottom; the accumulator fills from the top in the same way,
  // which leaves chunk 0 at the bottom after N shifts.
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_inv_in;
  logic             w_carry_in;
  logic             w_ovf_in;
  logic [CHUNK-1:0] w_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0] w_acc_next;

  // Decode of the incoming request. Abs of a negative value is a negate;
  // abs of a non-negative value is a plain pass.
  always_comb begin
    w_inv_in   = 1'b0;
    w_carry_in = 1'b0;
    w_ovf_in   = 1'b0;
    case (bus.mode)
      MODE_PASS: begin
        w_inv_in   = 1'b0;
        w_carry_in = 1'b0;
      end
      MODE_NEG: begin
        w_inv_in   = 1'b1;
        w_carry_in = 1'b1;
        w_ovf_in   = (bus.data == MIN_VAL);
      end
      MODE_ABS: begin
        w_inv_in   = bus.data[WIDTH-1];
        w_carry_in = bus.data[WIDTH-1];
        w_ovf_in   = (bus.data == MIN_VAL);
      end
      MODE_INV: begin
        w_inv_in   = 1'b1;
        w_carry_in = 1'b0;
      end
      default: begin
        w_inv_in   = 1'b0;
        w_carry_in = 1'b0;
      end
    endcase
  end

  // Chunk datapath: one CHUNK+1 bit add per cycle, carry kept in r_carry.
  always_comb begin
    w_chunk    = r_inv ? ~r_opnd[CHUNK-1:0] : r_opnd[CHUNK-1:0];
    w_sum      = {1'b0, w_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_cat      = {w_sum[CHUNK-1:0], r_acc};
    w_acc_next = w_cat[WIDTH+CHUNK-1:CHUNK];
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        // Back-to-back accept: no IDLE cycle, done still lasts one cycle.
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_inv      <= 1'b0;
      r_ovf_cand <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (w_accept) begin
        r_opnd     <= bus.data;
        r_idx      <= '0;
        r_inv      <= w_inv_in;
        r_carry    <= w_carry_in;
        r_ovf_cand <= w_ovf_in;
        r_busy     <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_opnd  <= r_opnd >> CHUNK;
        r_acc   <= w_acc_next;
        // Carry out of the top chunk is simply dropped on the next accept.
        r_carry <= w_sum[CHUNK];
        r_idx   <= r_idx + 1'b1;
        // Visible outputs change only on the final chunk, never mid-operation.
        if (w_last) begin
          r_result <= w_acc_next;
          r_zero   <= (w_acc_next == '0);
          r_ovf    <= r_ovf_cand;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_complement_seq.sv
// tb/tb_complement_seq.sv - scoreboard bench for complement_seq
//
// Purpose: drives directed and random operations into a 32/8 instance, pushes
// the expected outcome of every accepted operation into a queue and lets an
// independent monitor compare it on each done pulse; a second 8/8 instance
// covers the single-chunk configuration.
module tb_complement_seq;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        z;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  complement_seq_if #(.WIDTH(32)) bus32 ();
  complement_seq_if #(.WIDTH(8))  bus8 ();

  complement_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus32)
  );

  complement_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic meaning of each mode on a whole 32-bit word.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] d);
    exp_t e;
    logic [31:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = 32'd0 - d;
      2'b10:   r = d[31] ? 32'd0 - d : d;
      default: r = ~d;
    endcase
    e.r = r;
    e.o = ((m == 2'b01) || (m == 2'b10)) && (d == 32'h8000_0000);
    e.z = (r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (bus32.done === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done: got done with result 0x%08h, expected no completion", bus32.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus32.result !== e.r || bus32.ovf !== e.o || bus32.zero !== e.z) begin
          n_err++;
          $display("FAIL result: got r=0x%08h ovf=%b zero=%b, expected r=0x%08h ovf=%b zero=%b",
                   bus32.result, bus32.ovf, bus32.zero, e.r, e.o, e.z);
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus32.busy !== 1'b0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) chk("wait_idle_timeout", {31'd0, bus32.busy}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] m, input logic [31:0] d);
    wait_idle();
    bus32.start = 1'b1;
    bus32.mode  = m;
    bus32.data  = d;
    @(posedge clk);
    sb.push_back(model(m, d));
    #1;
    bus32.start = 1'b0;
    // Scramble inputs: they must not affect the operation in flight.
    bus32.data  = $urandom;
    bus32.mode  = 2'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;
    logic [7:0]  d8;
    logic [7:0]  r8;
    logic [1:0]  m;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus32.start = 1'b0; bus32.mode = 2'b00; bus32.data = '0;
    bus8.start  = 1'b0; bus8.mode  = 2'b00; bus8.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, bus32.busy}, 32'd0);
    chk("reset_done",   {31'd0, bus32.done}, 32'd0);
    chk("reset_result", bus32.result, 32'd0);
    chk("reset_ovf",    {31'd0, bus32.ovf}, 32'd0);
    chk("reset_zero",   {31'd0, bus32.zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Negate 1: latency of 4 edges, previous result held during RUN.
    issue(2'b01, 32'h0000_0001);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus32.done === 1'b1) begin
        lat = k;
        break;
      end
      chk("hold_during_run", bus32.result, 32'd0);
    end
    chk("latency", lat, 32'd4);
    chk("neg1_result", bus32.result, 32'hFFFF_FFFF);
    chk("neg1_ovf",    {31'd0, bus32.ovf}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, bus32.done}, 32'd0);

    // Directed boundary operands.
    issue(2'b01, 32'h8000_0000);
    issue(2'b10, 32'h8000_0000);
    issue(2'b10, 32'hFFFF_FF85);
    issue(2'b10, 32'h0000_007B);
    issue(2'b01, 32'h0000_0000);
    issue(2'b11, 32'h0F0F_0F0F);
    issue(2'b00, 32'h1234_5678);
    issue(2'b00, 32'h8000_0000);
    issue(2'b11, 32'h8000_0000);
    wait_idle();
    @(posedge clk);
    #1;
    chk("pass_min_no_ovf", {31'd0, bus32.ovf}, 32'd0);

    // Abort after two RUN edges: no result and no later done.
    issue(2'b01, 32'h0000_0005);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("abort_busy",   {31'd0, bus32.busy}, 32'd0);
    chk("abort_done",   {31'd0, bus32.done}, 32'd0);
    chk("abort_result", bus32.result, 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // START mid-RUN with different operand is ignored.
    issue(2'b00, 32'hA5A5_0001);
    bus32.start = 1'b1;
    bus32.mode  = 2'b01;
    bus32.data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    wait_idle();
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back: START held through FIN.
    bus32.start = 1'b1;
    bus32.mode  = 2'b10;
    bus32.data  = 32'hFFFF_FF85;
    @(posedge clk);
    sb.push_back(model(2'b10, 32'hFFFF_FF85));
    #1;
    bus32.mode = 2'b11;
    bus32.data = 32'h0F0F_0F0F;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_first_done", {31'd0, bus32.done}, 32'd1);
    @(posedge clk);
    sb.push_back(model(2'b11, 32'h0F0F_0F0F));
    #1;
    bus32.start = 1'b0;
    chk("b2b_busy_no_idle",  {31'd0, bus32.busy}, 32'd1);
    chk("b2b_done_unstretched", {31'd0, bus32.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_second_early", {31'd0, bus32.done}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_second_done",   {31'd0, bus32.done}, 32'd1);
    chk("b2b_second_result", bus32.result, 32'hF0F0_F0F0);

    // Random operations with biased operand choice.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      m = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       d = 32'h0000_0000;
        1:       d = 32'h8000_0000;
        2:       d = 32'hFFFF_FFFF;
        3:       d = 32'h0000_0001;
        4:       d = 32'h7FFF_FFFF;
        default: d = $urandom;
      endcase
      issue(m, d);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", sb.size(), 32'd0);

    // Single-chunk configuration: one edge of RUN.
    bus8.start = 1'b1;
    bus8.mode  = 2'b01;
    bus8.data  = 8'h05;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_done",   {31'd0, bus8.done}, 32'd1);
    chk("w8_result", {24'd0, bus8.result}, 32'h0000_00FB);
    for (int i = 0; i < 10; i++) begin
      m  = 2'($urandom);
      d8 = 8'($urandom);
      case (m)
        2'b00:   r8 = d8;
        2'b01:   r8 = 8'd0 - d8;
        2'b10:   r8 = d8[7] ? 8'd0 - d8 : d8;
        default: r8 = ~d8;
      endcase
      @(posedge clk);
      #1;
      bus8.start = 1'b1;
      bus8.mode  = m;
      bus8.data  = d8;
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      @(posedge clk);
      #1;
      chk("w8_rand_result", {24'd0, bus8.result}, {24'd0, r8});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
